// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C request arbiter: state encoding and the
// read/write command values used when latching a requester's transaction.
package i2c_arb_pkg;

  // State encoding of the arbiter sequencer
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] GUARD = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_GUARD = GUARD,
    ST_WAIT  = WAIT,
    ST_RESP  = RESP
  } arb_state_e;

  // Direction command values, matching the engine's macro definitions
  localparam logic I2C_WRITE_CMD = 1'b0;
  localparam logic I2C_READ_CMD  = 1'b1;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: starting just above the last
// served index and wrapping modulo NREQ, returns the first requester found
// as a one-hot vector and as an index.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);

  // Scan upward from last+1, first active request wins
  always_comb begin
    logic          found_s;
    logic [IW-1:0] cidx_s;
    int            cand_s;
    pick    = '0;
    idx     = '0;
    found_s = 1'b0;
    cidx_s  = '0;
    cand_s  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(last) + k) % NREQ;
      cidx_s = IW'(cand_s);
      if (!found_s && req[cidx_s]) begin
        found_s      = 1'b1;
        pick[cidx_s] = 1'b1;
        idx          = cidx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C register-access engine among NREQ
// requesters. Sequence: IDLE -> ISSUE -> GUARD -> WAIT -> RESP -> IDLE.
// Optional feature macro: I2C_ARB_TIMEOUT_EN adds a watchdog that forces a
// failed response after TIMEOUT_CYC cycles in GUARD/WAIT.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int GUARD_CYC   = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              CLOCK10,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_fail,
  output logic [AW-1:0]     i2c_reg_addr,
  output logic [DW-1:0]     i2c_wdata,
  output logic              i2c_write_req,
  output logic              i2c_read_req,
  input  logic              i2c_ready,
  input  logic [DW-1:0]     i2c_rdata,
  input  logic              i2c_rdata_valid,
  input  logic              i2c_fail,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GUARD_CYC) + 1;

  // Reject unsupported configurations at elaboration
  if (NREQ < 2 || NREQ > 8 || GUARD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("i2c_req_arbiter: unsupported parameter set");
  end

  arb_state_e      state_r, state_s;
  logic [NREQ-1:0] grant_r, grant_s, done_r, done_s;
  logic [IW-1:0]   gidx_r, gidx_s, last_r, last_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic [DW-1:0]   wdata_r, wdata_s, rdata_r, rdata_s, rsp_rdata_r, rsp_rdata_s;
  logic            rd_r, rd_s, fail_r, fail_s, rsp_fail_r, rsp_fail_s;
  logic            wr_req_r, wr_req_s, rd_req_r, rd_req_s, busy_r, busy_s;
  logic [GW-1:0]   gcnt_r, gcnt_s;
  logic [NREQ-1:0] pick_s;
  logic [IW-1:0]   pidx_s;
  logic            tmo_hit_s;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req  (req),
    .last (last_r),
    .pick (pick_s),
    .idx  (pidx_s)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  // Watchdog counts while a transaction is outstanding, clears otherwise
  always_ff @(posedge CLOCK10) begin
    if (!RESETN) begin
      tmo_cnt_r <= 32'd0;
    end else if (state_r == ST_GUARD || state_r == ST_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= 32'd0;
    end
  end

  assign tmo_hit_s = (tmo_cnt_r == 32'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; request/done pulses default low
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    gidx_s      = gidx_r;
    last_s      = last_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rd_s        = rd_r;
    fail_s      = fail_r;
    rdata_s     = rdata_r;
    gcnt_s      = gcnt_r;
    done_s      = '0;
    rsp_rdata_s = '0;
    rsp_fail_s  = 1'b0;
    wr_req_s    = 1'b0;
    rd_req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((|req) && i2c_ready) begin
          grant_s = pick_s;
          gidx_s  = pidx_s;
          addr_s  = req_addr[pidx_s*AW +: AW];
          wdata_s = req_wdata[pidx_s*DW +: DW];
          rd_s    = req_rd[pidx_s];
          fail_s  = 1'b0;
          rdata_s = '0;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_r == I2C_READ_CMD) begin
          rd_req_s = 1'b1;
        end else begin
          wr_req_s = 1'b1;
        end
        gcnt_s  = '0;
        state_s = ST_GUARD;
      end
      ST_GUARD: begin
        fail_s = fail_r | i2c_fail;
        if (tmo_hit_s) begin
          done_s     = grant_r;
          rsp_fail_s = 1'b1;
          state_s    = ST_RESP;
        end else if (gcnt_r == GW'(GUARD_CYC - 1)) begin
          state_s = ST_WAIT;
        end else begin
          gcnt_s = gcnt_r + GW'(1);
        end
      end
      ST_WAIT: begin
        fail_s = fail_r | i2c_fail;
        if (i2c_rdata_valid) begin
          rdata_s = i2c_rdata;
        end else begin
          rdata_s = rdata_r;
        end
        if (tmo_hit_s) begin
          done_s     = grant_r;
          rsp_fail_s = 1'b1;
          state_s    = ST_RESP;
        end else if (i2c_ready) begin
          done_s      = grant_r;
          rsp_fail_s  = fail_r | i2c_fail;
          rsp_rdata_s = (rd_r == I2C_READ_CMD) ? rdata_s : '0;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        grant_s = '0;
        last_s  = gidx_r;
        fail_s  = 1'b0;
        rdata_s = '0;
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State register
  always_ff @(posedge CLOCK10) begin
    if (!RESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK10) begin
    if (!RESETN) begin
      grant_r     <= '0;
      done_r      <= '0;
      gidx_r      <= '0;
      last_r      <= IW'(NREQ - 1);
      addr_r      <= '0;
      wdata_r     <= '0;
      rd_r        <= 1'b0;
      fail_r      <= 1'b0;
      rdata_r     <= '0;
      gcnt_r      <= '0;
      rsp_rdata_r <= '0;
      rsp_fail_r  <= 1'b0;
      wr_req_r    <= 1'b0;
      rd_req_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      grant_r     <= grant_s;
      done_r      <= done_s;
      gidx_r      <= gidx_s;
      last_r      <= last_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rd_r        <= rd_s;
      fail_r      <= fail_s;
      rdata_r     <= rdata_s;
      gcnt_r      <= gcnt_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_fail_r  <= rsp_fail_s;
      wr_req_r    <= wr_req_s;
      rd_req_r    <= rd_req_s;
      busy_r      <= busy_s;
    end
  end

  assign grant         = grant_r;
  assign done          = done_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_fail      = rsp_fail_r;
  assign i2c_reg_addr  = addr_r;
  assign i2c_wdata     = wdata_r;
  assign i2c_write_req = wr_req_r;
  assign i2c_read_req  = rd_req_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a behavioural I2C engine
// model. Define I2C_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_i2c_req_arbiter;

  localparam int NREQ = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int GUARD_CYC = 4;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 100;
`else
  localparam int TIMEOUT_CYC = 2000000;
`endif

  logic CLOCK10 = 1'b0;
  logic RESETN = 1'b0;
  logic [NREQ-1:0] req = '0, req_rd = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] grant, done;
  logic [DW-1:0] rsp_rdata, i2c_wdata;
  logic [AW-1:0] i2c_reg_addr;
  logic rsp_fail, i2c_write_req, i2c_read_req, busy;
  logic i2c_ready = 1'b1, i2c_rdata_valid = 1'b0, i2c_fail = 1'b0;
  logic [DW-1:0] i2c_rdata = '0;

  int total = 0;
  int bad = 0;

  // engine model controls and record of what it was asked to do
  logic e_busy = 1'b0, e_hang = 1'b0, e_fail_arm = 1'b0, e_rd = 1'b0;
  logic [7:0] e_rdval = 8'h00, e_addr = 8'h00, e_wdata = 8'h00;
  int e_npulse = 0, e_cnt = 0, e_lat = 0, e_lat_fix = 0;

  always #50 CLOCK10 = ~CLOCK10;

  i2c_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .GUARD_CYC(GUARD_CYC),
                    .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLOCK10(CLOCK10), .RESETN(RESETN), .req(req), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_fail(rsp_fail), .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata(i2c_wdata), .i2c_write_req(i2c_write_req),
    .i2c_read_req(i2c_read_req), .i2c_ready(i2c_ready), .i2c_rdata(i2c_rdata),
    .i2c_rdata_valid(i2c_rdata_valid), .i2c_fail(i2c_fail), .busy(busy));

  // Behavioural engine: accepts one request, drops ready after 2 cycles,
  // optionally flags failure, returns read data, then raises ready again.
  initial begin : engine
    forever begin
      @(negedge CLOCK10);
      i2c_rdata_valid = 1'b0;
      i2c_fail = 1'b0;
      if (!RESETN) begin
        i2c_ready = 1'b1;
        e_busy = 1'b0;
      end else if (i2c_write_req || i2c_read_req) begin
        total++;
        if (e_busy || (i2c_write_req && i2c_read_req)) begin
          bad++;
          $display("FAIL outstanding: engine busy=%0b wr=%0b rd=%0b, want one request at a time",
                   e_busy, i2c_write_req, i2c_read_req);
        end
        e_npulse++;
        e_rd = i2c_read_req;
        e_addr = i2c_reg_addr;
        e_wdata = i2c_wdata;
        e_busy = 1'b1;
        e_lat = (e_lat_fix != 0) ? e_lat_fix : int'($urandom_range(3, 10));
        e_cnt = e_lat + 2;
        if (e_hang) i2c_ready = 1'b0;
      end else if (e_busy && !e_hang) begin
        e_cnt--;
        if (e_cnt == e_lat) i2c_ready = 1'b0;
        if (e_cnt == 2 && e_fail_arm) i2c_fail = 1'b1;
        if (e_cnt == 1 && e_rd) begin
          i2c_rdata_valid = 1'b1;
          i2c_rdata = e_rdval;
        end
        if (e_cnt == 0) begin
          i2c_ready = 1'b1;
          e_busy = 1'b0;
        end
      end
    end
  end

  // round-robin rule: first requester above 'last', wrapping
  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // post one transaction from requester k and collect what came back
  task automatic run_txn(input int k, input logic rd, input logic [7:0] addr,
                         input logic [7:0] wd, input logic farm, input logic [7:0] rv,
                         output logic [NREQ-1:0] g, output logic [NREQ-1:0] d,
                         output logic [7:0] rdat, output logic rf,
                         output int npulse, output logic to);
    int n0;
    n0 = e_npulse;
    e_fail_arm = farm;
    e_rdval = rv;
    req_rd[k] = rd;
    req_addr[k*AW +: AW] = addr;
    req_wdata[k*DW +: DW] = wd;
    req[k] = 1'b1;
    g = '0; d = '0; rdat = '0; rf = 1'b0; to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLOCK10);
      if (grant != '0 && g == '0) g = grant;
      if (done != '0) begin
        d = done; rdat = rsp_rdata; rf = rsp_fail; to = 1'b0;
        break;
      end
    end
    req[k] = 1'b0;
    e_fail_arm = 1'b0;
    npulse = e_npulse - n0;
    @(negedge CLOCK10);
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (3) @(negedge CLOCK10);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", grant); end
    total++; if (done !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({i2c_write_req, i2c_read_req, rsp_fail} !== 3'b000 || rsp_rdata !== 8'h00)
      begin bad++; $display("FAIL reset_outs: got wr=%b rd=%b fail=%b rdata=%h want 0", i2c_write_req, i2c_read_req, rsp_fail, rsp_rdata); end
    RESETN = 1'b1;
  endtask

  task automatic test_write();
    logic got;
    int n0;
    n0 = e_npulse;
    req_rd[0] = 1'b0; req_addr[7:0] = 8'h0D; req_wdata[7:0] = 8'h21; req[0] = 1'b1;
    @(negedge CLOCK10);
    total++; if (grant !== 3'b001 || busy !== 1'b1 || i2c_write_req !== 1'b0)
      begin bad++; $display("FAIL wr_grant: got grant=%b busy=%b wr=%b want 001 1 0", grant, busy, i2c_write_req); end
    @(negedge CLOCK10);
    total++; if (i2c_write_req !== 1'b1 || i2c_read_req !== 1'b0)
      begin bad++; $display("FAIL wr_pulse: got wr=%b rd=%b want 1 0", i2c_write_req, i2c_read_req); end
    total++; if (i2c_reg_addr !== 8'h0D || i2c_wdata !== 8'h21)
      begin bad++; $display("FAIL wr_bus: got addr=%h data=%h want 0d 21", i2c_reg_addr, i2c_wdata); end
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge CLOCK10);
      if (done != '0) got = 1'b1;
    end
    total++; if (!got || done !== 3'b001)
      begin bad++; $display("FAIL wr_done: got %b want 001", done); end
    total++; if (rsp_fail !== 1'b0 || rsp_rdata !== 8'h00)
      begin bad++; $display("FAIL wr_rsp: got fail=%b rdata=%h want 0 00", rsp_fail, rsp_rdata); end
    req[0] = 1'b0;
    @(negedge CLOCK10);
    total++; if (done !== 3'b000 || grant !== 3'b000 || busy !== 1'b0)
      begin bad++; $display("FAIL wr_after: got done=%b grant=%b busy=%b want 0", done, grant, busy); end
    total++; if (e_npulse - n0 != 1)
      begin bad++; $display("FAIL wr_npulse: got %0d want 1", e_npulse - n0); end
  endtask

  task automatic test_read();
    logic [NREQ-1:0] g, d; logic [7:0] rdat; logic rf, to; int np;
    run_txn(1, 1'b1, 8'h00, 8'h5A, 1'b0, 8'h15, g, d, rdat, rf, np, to);
    total++; if (to || d !== 3'b010 || g !== 3'b010)
      begin bad++; $display("FAIL rd_done: got grant=%b done=%b want 010", g, d); end
    total++; if (rdat !== 8'h15 || rf !== 1'b0)
      begin bad++; $display("FAIL rd_rsp: got rdata=%h fail=%b want 15 0", rdat, rf); end
    total++; if (np != 1 || e_rd !== 1'b1 || e_addr !== 8'h00)
      begin bad++; $display("FAIL rd_engine: got pulses=%0d rd=%b addr=%h want 1 1 00", np, e_rd, e_addr); end
  endtask

  task automatic test_contention();
    logic got, rd_exp; logic [7:0] rv; int last, exp;
    RESETN = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i] = 1'($urandom); req_addr[i*AW +: AW] = 8'($urandom); req_wdata[i*DW +: DW] = 8'($urandom);
    end
    req = 3'b111;
    repeat (2) @(negedge CLOCK10);
    RESETN = 1'b1;
    last = NREQ - 1;
    for (int t = 0; t < 6; t++) begin
      rv = 8'($urandom); e_rdval = rv;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge CLOCK10);
        if (grant != '0) got = 1'b1;
      end
      exp = rr_next(req, last);
      rd_exp = req_rd[exp];
      total++; if (!got || grant !== (3'b001 << exp))
        begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", t, grant, 3'b001 << exp); end
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge CLOCK10);
        if (done != '0) got = 1'b1;
      end
      total++; if (!got || done !== (3'b001 << exp))
        begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", t, done, 3'b001 << exp); end
      total++; if (rsp_rdata !== (rd_exp ? rv : 8'h00))
        begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", t, rsp_rdata, rd_exp ? rv : 8'h00); end
      req[exp] = 1'b0;
      req_rd[exp] = 1'($urandom); req_addr[exp*AW +: AW] = 8'($urandom);
      last = exp;
      if (t < 5) begin
        @(negedge CLOCK10);
        req[exp] = 1'b1;
      end else begin
        req = '0;
      end
    end
    repeat (2) @(negedge CLOCK10);
  endtask

  task automatic test_nack();
    logic [NREQ-1:0] g, d; logic [7:0] rdat, rv; logic rf, to; int np;
    run_txn(2, 1'b0, 8'h33, 8'h44, 1'b1, 8'h00, g, d, rdat, rf, np, to);
    total++; if (to || d !== 3'b100 || rf !== 1'b1)
      begin bad++; $display("FAIL nack_fail: got done=%b fail=%b want 100 1", d, rf); end
    rv = 8'($urandom);
    run_txn(2, 1'b1, 8'h34, 8'h00, 1'b0, rv, g, d, rdat, rf, np, to);
    total++; if (to || d !== 3'b100 || rf !== 1'b0 || rdat !== rv)
      begin bad++; $display("FAIL nack_next: got done=%b fail=%b rdata=%h want 100 0 %h", d, rf, rdat, rv); end
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g, d; logic [7:0] rdat; logic rf, to, early; int np;
    e_lat_fix = 20;
    req_rd[0] = 1'b1; req_addr[7:0] = 8'h10; req[0] = 1'b1;
    early = 1'b0;
    repeat (9) begin
      @(negedge CLOCK10);
      if (done != '0) early = 1'b1;
    end
    total++; if (early || busy !== 1'b1)
      begin bad++; $display("FAIL mid_busy: got busy=%b early_done=%b want 1 0", busy, early); end
    RESETN = 1'b0; req[0] = 1'b0;
    @(negedge CLOCK10);
    RESETN = 1'b1;
    total++; if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_reset: got grant=%b done=%b busy=%b want 0", grant, done, busy); end
    total++; if (i2c_write_req !== 1'b0 || i2c_read_req !== 1'b0)
      begin bad++; $display("FAIL mid_pulse: got wr=%b rd=%b want 0 0", i2c_write_req, i2c_read_req); end
    e_lat_fix = 0;
    run_txn(1, 1'b0, 8'h22, 8'h99, 1'b0, 8'h00, g, d, rdat, rf, np, to);
    total++; if (to || d !== 3'b010 || rf !== 1'b0 || np != 1)
      begin bad++; $display("FAIL mid_next: got done=%b fail=%b pulses=%0d want 010 0 1", d, rf, np); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, d; logic [7:0] rdat, addr, wd, rv; logic rf, to, rd, farm; int np, k;
    for (int t = 0; t < 10; t++) begin
      k = int'($urandom_range(0, NREQ - 1));
      rd = 1'($urandom); addr = 8'($urandom); wd = 8'($urandom); rv = 8'($urandom);
      farm = ($urandom_range(0, 3) == 0);
      run_txn(k, rd, addr, wd, farm, rv, g, d, rdat, rf, np, to);
      total++; if (to || d !== (3'b001 << k) || g !== (3'b001 << k))
        begin bad++; $display("FAIL rnd_done[%0d]: got grant=%b done=%b want %b", t, g, d, 3'b001 << k); end
      total++; if (rdat !== (rd ? rv : 8'h00) || rf !== farm)
        begin bad++; $display("FAIL rnd_rsp[%0d]: got rdata=%h fail=%b want %h %b", t, rdat, rf, rd ? rv : 8'h00, farm); end
      total++; if (np != 1 || e_rd !== rd || e_addr !== addr || (!rd && e_wdata !== wd))
        begin bad++; $display("FAIL rnd_engine[%0d]: got pulses=%0d rd=%b addr=%h data=%h want 1 %b %h %h", t, np, e_rd, e_addr, e_wdata, rd, addr, wd); end
    end
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic got, pulsed, granted; int cyc;
    e_hang = 1'b1;
    req_rd[0] = 1'b1; req_addr[7:0] = 8'h05; req[0] = 1'b1;
    got = 1'b0; pulsed = 1'b0; cyc = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge CLOCK10);
      if (i2c_read_req) pulsed = 1'b1;
      if (pulsed) cyc++;
      if (done != '0) got = 1'b1;
    end
    total++; if (!got || cyc - 1 > TIMEOUT_CYC + GUARD_CYC + 2)
      begin bad++; $display("FAIL tmo_latency: got done=%b after %0d cycles want <= %0d", done, cyc - 1, TIMEOUT_CYC + GUARD_CYC + 2); end
    total++; if (rsp_fail !== 1'b1 || rsp_rdata !== 8'h00)
      begin bad++; $display("FAIL tmo_rsp: got fail=%b rdata=%h want 1 00", rsp_fail, rsp_rdata); end
    req[0] = 1'b0;
    @(negedge CLOCK10);
    req[0] = 1'b1;
    granted = 1'b0;
    repeat (5) begin
      @(negedge CLOCK10);
      if (grant != '0) granted = 1'b1;
    end
    total++; if (granted)
      begin bad++; $display("FAIL tmo_hold: got a grant while engine not ready, want none"); end
    req[0] = 1'b0; e_hang = 1'b0;
    RESETN = 1'b0;
    repeat (2) @(negedge CLOCK10);
    RESETN = 1'b1;
  endtask
`endif

  // overall time limit
  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_nack();
    test_reset_mid();
    test_random();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
